// File: rtl/register_pkg.sv
// Shared constants and the default word type for the register storage element.
package register_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  localparam word_t DEFAULT_RESET_VALUE = '0;

endpackage : register_pkg

// File: rtl/register_bit.sv
// Single-bit D flop with synchronous load enable and asynchronous active-low clear
// to a per-bit reset constant.
module register_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // NOTE: reset sits in the sensitivity list so clearing is immediate, and state
  // is written with <= so every bit samples d from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register_bit

// File: rtl/register.sv
// Parameterised load-enable register built from WIDTH register_bit flops.
// Optional embedded checks are compiled in when REGISTER_ASSERT_EN is defined.
module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    register_bit #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[i]),
      .q   (q[i])
    );
  end

`ifdef REGISTER_ASSERT_EN
  a_load : assert property (@(posedge clk) disable iff (!rst) en |=> q == $past(d));
  a_hold : assert property (@(posedge clk) disable iff (!rst) !en |=> $stable(q));

  // Sampled mid-cycle so the asynchronous clear has settled before the check.
  always @(negedge clk) begin
    if (!rst) begin
      a_reset : assert (q == RESET_VALUE);
    end
  end

  c_en   : cover property (@(posedge clk) disable iff (!rst) en);
  c_zero : cover property (@(posedge clk) disable iff (!rst) d == '0);
  c_ones : cover property (@(posedge clk) disable iff (!rst) d == '1);
`endif

endmodule : register

// File: tb/tb_register.sv
// Self-checking bench for register: default 32-bit build plus 1-bit and 64-bit
// all-ones-reset variants, compared against a cycle-level behavioural model.
module tb_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] d32 = '0;
  logic [63:0] d64 = '0;
  logic        d1  = 1'b0;
  logic [31:0] q32;
  logic [63:0] q64;
  logic        q1;

  // Model state: what each register must hold after the most recent edge.
  logic [31:0] exp32;
  logic [63:0] exp64;
  logic        exp1;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] ONES64 = {64{1'b1}};

  always #5 clk = ~clk;

  register u_dut32 (
    .clk (clk), .rst (rst), .en (en), .d (d32), .q (q32)
  );

  register #(.WIDTH(64), .RESET_VALUE(ONES64)) u_dut64 (
    .clk (clk), .rst (rst), .en (en), .d (d64), .q (q64)
  );

  register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut1 (
    .clk (clk), .rst (rst), .en (en), .d (d1), .q (q1)
  );

  // Drives one cycle of inputs at the falling edge, advances the model by the
  // register's rules, and returns just after the following rising edge.
  task automatic tick(input logic e, input logic [31:0] a, input logic [63:0] b,
                      input logic c);
    @(negedge clk);
    en  = e;
    d32 = a;
    d64 = b;
    d1  = c;
    if (!rst) begin
      exp32 = 32'h0;
      exp64 = ONES64;
      exp1  = 1'b1;
    end else if (e) begin
      exp32 = a;
      exp64 = b;
      exp1  = c;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 32'hDEADBEEF, 64'hDEADBEEF_DEADBEEF, 1'b0);
      n_vec += 3;
      if (q32 !== 32'h0) begin
        n_err++; $display("FAIL reset_q32 cycle %0d: got %h want %h", i, q32, 32'h0);
      end
      if (q64 !== ONES64) begin
        n_err++; $display("FAIL reset_q64 cycle %0d: got %h want %h", i, q64, ONES64);
      end
      if (q1 !== 1'b1) begin
        n_err++; $display("FAIL reset_q1 cycle %0d: got %b want 1", i, q1);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 32'hDEADBEEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    n_vec += 3;
    if (q32 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL release_load_q32: got %h want %h", q32, 32'hDEADBEEF);
    end
    if (q64 !== 64'h0123_4567_89AB_CDEF) begin
      n_err++; $display("FAIL release_load_q64: got %h want %h", q64, 64'h0123_4567_89AB_CDEF);
    end
    if (q1 !== 1'b0) begin
      n_err++; $display("FAIL release_load_q1: got %b want 0", q1);
    end
  endtask

  task automatic test_boundary;
    tick(1'b1, 32'h0, 64'h0, 1'b0);
    n_vec += 3;
    if (q32 !== 32'h0) begin
      n_err++; $display("FAIL zeros_q32: got %h want %h", q32, 32'h0);
    end
    if (q64 !== 64'h0) begin
      n_err++; $display("FAIL zeros_q64: got %h want %h", q64, 64'h0);
    end
    if (q1 !== 1'b0) begin
      n_err++; $display("FAIL zeros_q1: got %b want 0", q1);
    end
    tick(1'b1, 32'hFFFFFFFF, ONES64, 1'b1);
    n_vec += 3;
    if (q32 !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL ones_q32: got %h want %h", q32, 32'hFFFFFFFF);
    end
    if (q64 !== ONES64) begin
      n_err++; $display("FAIL ones_q64: got %h want %h", q64, ONES64);
    end
    if (q1 !== 1'b1) begin
      n_err++; $display("FAIL ones_q1: got %b want 1", q1);
    end
  endtask

  task automatic test_hold;
    tick(1'b1, 32'h12345678, 64'h1122_3344_5566_7788, 1'b1);
    n_vec++;
    if (q32 !== 32'h12345678) begin
      n_err++; $display("FAIL hold_load_q32: got %h want %h", q32, 32'h12345678);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 32'hA5A5A5A5, 64'hA5A5A5A5_A5A5A5A5, 1'b0);
      n_vec += 3;
      if (q32 !== 32'h12345678) begin
        n_err++; $display("FAIL hold_q32 cycle %0d: got %h want %h", i, q32, 32'h12345678);
      end
      if (q64 !== 64'h1122_3344_5566_7788) begin
        n_err++; $display("FAIL hold_q64 cycle %0d: got %h want %h", i, q64, 64'h1122_3344_5566_7788);
      end
      if (q1 !== 1'b1) begin
        n_err++; $display("FAIL hold_q1 cycle %0d: got %b want 1", i, q1);
      end
    end
  endtask

  task automatic test_async_reset;
    tick(1'b1, 32'hCAFEF00D, 64'h0, 1'b0);
    n_vec++;
    if (q32 !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL async_preload_q32: got %h want %h", q32, 32'hCAFEF00D);
    end
    // Now 1 time unit after the rising edge; drop reset well before the next one.
    #2;
    rst = 1'b0;
    #1;
    n_vec += 3;
    if (q32 !== 32'h0) begin
      n_err++; $display("FAIL async_q32: got %h want %h", q32, 32'h0);
    end
    if (q64 !== ONES64) begin
      n_err++; $display("FAIL async_q64: got %h want %h", q64, ONES64);
    end
    if (q1 !== 1'b1) begin
      n_err++; $display("FAIL async_q1: got %b want 1", q1);
    end
    // Enabled edges during reset must be ignored.
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 32'h55AA55AA, 64'h0, 1'b0);
      n_vec++;
      if (q32 !== 32'h0) begin
        n_err++; $display("FAIL async_ignore_q32 cycle %0d: got %h want %h", i, q32, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 10000; i++) begin
      tick(1'($urandom_range(0, 1)), 32'($urandom), {32'($urandom), 32'($urandom)},
           1'($urandom_range(0, 1)));
      n_vec += 3;
      if (q32 !== exp32) begin
        n_err++; $display("FAIL rand_q32 cycle %0d: got %h want %h", i, q32, exp32);
      end
      if (q64 !== exp64) begin
        n_err++; $display("FAIL rand_q64 cycle %0d: got %h want %h", i, q64, exp64);
      end
      if (q1 !== exp1) begin
        n_err++; $display("FAIL rand_q1 cycle %0d: got %b want %b", i, q1, exp1);
      end
    end
  endtask

  initial begin
    exp32 = 32'h0;
    exp64 = ONES64;
    exp1  = 1'b1;
    test_reset();
    test_boundary();
    test_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_register

// File: doc/register.md
# register

Parameterised D-type storage register with synchronous load enable and asynchronous clear. It is the basic state-holding element of the RISC-V core, used for the program counter, pipeline registers, and other architectural and datapath state. Each rising clock edge with the enable high captures the data input. With the enable low, the stored value is held. Reset forces the stored value to a fixed constant.

## Interface
- Parameters:
  - WIDTH, default 32: data width in bits; legal range 1 and up.
  - RESET_VALUE, default all-zeros (WIDTH bits): value loaded into q during reset.
- Ports:
  - clk  input  1  rising-edge clock.
  - rst  input  1  reset, asynchronous and active-low (rst = 0 resets).
  - en  input  1  load enable, active-high.
  - d  input  WIDTH  data to capture.
  - q  output  WIDTH  stored value, driven directly from flops.
- One clock domain; reset is asynchronous and active-low.

## Operation
- rst = 0: q = RESET_VALUE. The default RESET_VALUE is 0.
- rst = 1, rising clk, en = 1: q <= d. The full WIDTH bits are captured; no truncation or extension.
- rst = 1, rising clk, en = 0: q holds its previous value, with no bit change.
- Reset has priority over en and clk. While rst = 0, edges with en = 1 are ignored.
- All WIDTH bits update together; there are no partial or byte writes.
- No combinational path exists from d or en to q.
- en and d are sampled only at the clock edge. Glitches between edges have no effect.

## Timing
- Load latency is 1 cycle: d presented before edge N appears on q just after edge N and remains until the next enabled edge.
- Reset assertion is immediate and asynchronous: q becomes RESET_VALUE without waiting for a clock edge, including mid-cycle.
- Reset release is synchronous in effect: the first load occurs at the first rising edge where rst = 1 and en = 1.
- If rst deasserts coincident with a rising edge, that edge does not load. The first load happens at the following edge.
- Back-to-back enabled cycles load on every edge, giving a throughput of one value per cycle.
- en = 0 for any number of cycles keeps q bit-exactly stable.

## Configuration
- Macro: REGISTER_ASSERT_EN.
- Defined: the module compiles in embedded concurrent checks, each disabled while rst = 0:
  - en |=> q == $past(d)
  - !en |=> $stable(q)
  - an immediate check that q == RESET_VALUE whenever rst = 0
  - cover points for en, d == 0, and d == all-ones
- Not defined: the checks are absent; pure storage RTL with identical functional behaviour.

## Structure
- Package register_pkg holds the shared constants:
  - DEFAULT_WIDTH = 32
  - a typedef for the default-width word (logic [DEFAULT_WIDTH-1:0])
  - the default reset constant (all-zeros)
- register uses the package values as its parameter defaults.
- Sub-module register_bit is a single-bit flop with async active-low clear to a per-bit reset value and a synchronous enable.
- register instantiates WIDTH copies of register_bit through a generate loop. Bit i takes RESET_VALUE[i].
- Assertions live in a REGISTER_ASSERT_EN-guarded section of register. They are not placed in register_bit.

## Test plan
- Reset: hold rst = 0 for 5 cycles with en = 1 and d = 0xDEADBEEF -> q = 0x00000000 throughout. Release; next edge with en = 1 -> q = 0xDEADBEEF.
- Boundary values: en = 1, d = 0x00000000 -> q = 0x00000000 one edge later. Then d = 0xFFFFFFFF -> q = 0xFFFFFFFF one edge later.
- Hold: load 0x12345678, then set en = 0 and drive d = 0xA5A5A5A5 for 10 cycles -> q stays 0x12345678.
- Asynchronous reset mid-cycle: q = 0xCAFEF00D, assert rst = 0 halfway between edges -> q = 0x00000000 immediately, before the next edge.
- Random regression: 10000 cycles of random d and en -> each edge with en = 1 gives q == d from that edge; each edge with en = 0 gives q unchanged.
- Parameter sweep:
  - WIDTH = 1 and WIDTH = 64 with RESET_VALUE = all-ones -> q = all-ones during reset, and correct load/hold afterwards.
